config_commit_ctrl: RTL and testbench

CONFIG_COMMIT_CTRL -- requirements
Module: config_commit_ctrl

---
 rtl/config_commit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_config_commit_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_commit_ctrl.sv
// ============================================================================
// Module : config_commit_ctrl
// Brief  : Collects SPI bytes into a shadow word and commits it to config_out
//          on the next frame_start. Build option: CONFIG_CHECKSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_commit_ctrl #(
  parameter logic [31:0] RESET_CONFIG   = 32'hBBFC0000,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        frame_start,
  output logic [31:0] config_out,
  output logic        commit,
  output logic        char_wr,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_limit = TMO_W'(TIMEOUT_CYCLES);
`ifdef CONFIG_CHECKSUM_EN
  localparam logic [2:0] c_last_idx = 3'd4;
`else
  localparam logic [2:0] c_last_idx = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      cfg_q, cfg_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             commit_q, commit_d;
  logic             char_wr_q, char_wr_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic [TMO_W-1:0] w_tmo_inc;

  assign w_tmo_inc = tmo_q + 1'b1;

`ifdef CONFIG_CHECKSUM_EN
  logic [7:0] w_xor;
  assign w_xor = shadow_q[31:24] ^ shadow_q[23:16] ^ shadow_q[15:8] ^ shadow_q[7:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cfg_q       <= RESET_CONFIG;
      cnt_q       <= '0;
      tmo_q       <= '0;
      commit_q    <= 1'b0;
      char_wr_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      commit_q    <= commit_d;
      char_wr_q   <= char_wr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    commit_d    = 1'b0;
    char_wr_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ss) begin
          state_d  = COLLECT;
          cnt_d    = '0;
          tmo_d    = '0;
          shadow_d = '0;
        end
      end

      COLLECT: begin
        if (ss) begin
          frame_err_d = 1'b1;
          shadow_d    = '0;
          state_d     = IDLE;
        end else if (byte_valid) begin
          tmo_d = '0;
          cnt_d = cnt_q + 3'd1;
`ifdef CONFIG_CHECKSUM_EN
          // Fifth byte is only compared, never shifted into the word.
          if (cnt_q == c_last_idx) begin
            if (byte_data == w_xor) begin
              state_d = PENDING;
            end else begin
              frame_err_d = 1'b1;
              shadow_d    = '0;
              state_d     = IDLE;
            end
          end else begin
            shadow_d = {shadow_q[23:0], byte_data};
          end
`else
          shadow_d = {shadow_q[23:0], byte_data};
          if (cnt_q == c_last_idx) begin
            state_d = PENDING;
          end
`endif
        end else if (w_tmo_inc == c_tmo_limit) begin
          frame_err_d = 1'b1;
          shadow_d    = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = w_tmo_inc;
        end
      end

      PENDING: begin
        overrun_d = byte_valid;
        if (frame_start) begin
          cfg_d     = shadow_q;
          commit_d  = 1'b1;
          char_wr_d = shadow_q[21];
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign config_out = cfg_q;
  assign commit     = commit_q;
  assign char_wr    = char_wr_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_config_commit_ctrl.sv
// ============================================================================
// Module : tb_config_commit_ctrl
// Brief  : Scoreboard bench: committed words queued at stimulus, popped on commit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_config_commit_ctrl;

  localparam logic [31:0] RESET_CFG = 32'hBBFC0000;
  localparam int          TMO       = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ss = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        frame_start = 1'b0;
  logic [31:0] config_out;
  logic        commit, char_wr, frame_err, overrun, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int ovr_cnt  = 0;
  logic [31:0] sb[$];
  logic [31:0] cfg_exp = RESET_CFG;
  logic        prev_err = 1'b0;
  logic        prev_ovr = 1'b0;

  config_commit_ctrl #(
    .RESET_CONFIG  (RESET_CFG),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_start(frame_start),
    .config_out (config_out),
    .commit     (commit),
    .char_wr    (char_wr),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: scoreboard pop on commit, config_out must hold otherwise.
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      cfg_exp  = RESET_CFG;
      prev_err = 1'b0;
      prev_ovr = 1'b0;
    end else begin
      if (commit) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_commit config_out=%h", config_out);
        end else begin
          w = sb.pop_front();
          if (config_out !== w || char_wr !== w[21])
            $display("FAIL commit_word got=%h char_wr=%b want=%h char_wr=%b",
                     config_out, char_wr, w, w[21]);
          else n_pass++;
          cfg_exp = w;
        end
      end
      n_checks++;
      if (config_out !== cfg_exp || (!commit && char_wr !== 1'b0))
        $display("FAIL config_hold got=%h char_wr=%b want=%h", config_out, char_wr, cfg_exp);
      else n_pass++;
      if (frame_err) begin
        err_cnt++;
        if (prev_err) begin
          n_checks++;
          $display("FAIL frame_err_width got=2+ cycles want=1");
        end
      end
      if (overrun) begin
        ovr_cnt++;
        if (prev_ovr) begin
          n_checks++;
          $display("FAIL overrun_width got=2+ cycles want=1");
        end
      end
      prev_err = frame_err;
      prev_ovr = overrun;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic open_frame();
    ss = 1'b0;
    tick();
  endtask

  // Sends a whole frame (plus checksum when enabled) and queues the word.
  task automatic send_frame(input logic [31:0] w);
    open_frame();
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
`ifdef CONFIG_CHECKSUM_EN
    send_byte(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    ss = 1'b1;
    sb.push_back(w);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_commit(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 10) begin
      tick();
      k++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_commit_timeout pending=%0d want=0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (config_out !== RESET_CFG || commit !== 1'b0 || char_wr !== 1'b0 ||
        frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_state cfg=%h c=%b cw=%b fe=%b ov=%b busy=%b want=%h/0/0/0/0/0",
               config_out, commit, char_wr, frame_err, overrun, busy, RESET_CFG);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (config_out !== RESET_CFG || busy !== 1'b0)
      $display("FAIL reset_release cfg=%h busy=%b want=%h/0", config_out, busy, RESET_CFG);
    else n_pass++;
  endtask

  task automatic test_basic();
    send_frame(32'h12345678);
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1 || config_out !== RESET_CFG)
      $display("FAIL basic_pending busy=%b cfg=%h want=1/%h", busy, config_out, RESET_CFG);
    else n_pass++;
    pulse_fs();
    wait_commit("basic");
    tick();
    n_checks++;
    if (busy !== 1'b0 || config_out !== 32'h12345678)
      $display("FAIL basic_after busy=%b cfg=%h want=0/12345678", busy, config_out);
    else n_pass++;
  endtask

  task automatic test_char_wr();
    send_frame(32'h00208000);
    pulse_fs();
    wait_commit("char_wr");
  endtask

  task automatic test_abort();
    int e0 = err_cnt;
    open_frame();
    send_byte(8'hAA);
    send_byte(8'hBB);
    ss = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (err_cnt - e0 != 1 || busy !== 1'b0 || sb.size() != 0)
      $display("FAIL abort_frame_err got=%0d busy=%b want=1/0", err_cnt - e0, busy);
    else n_pass++;
    send_frame(32'hA5C3_0F11);
    pulse_fs();
    wait_commit("abort_follow");
  endtask

  task automatic test_timeout();
    int first = -1;
    open_frame();
    send_byte(8'h11);
    for (int k = 1; k <= TMO + 5 && first < 0; k++) begin
      tick();
      if (frame_err === 1'b1) begin
        first = k;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL timeout_idle busy=%b want=0", busy);
        else n_pass++;
      end
    end
    ss = 1'b1;
    n_checks++;
    if (first != TMO) $display("FAIL timeout_cycles got=%0d want=%0d", first, TMO);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_overrun();
    logic [31:0] w = 32'hCAFE1234;
    logic [7:0]  last;
    int o0 = ovr_cnt;
    open_frame();
`ifdef CONFIG_CHECKSUM_EN
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    last = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`else
    for (int i = 3; i >= 1; i--) send_byte(w[i*8 +: 8]);
    last = w[7:0];
`endif
    sb.push_back(w);
    frame_start = 1'b1;
    send_byte(last);
    frame_start = 1'b0;
    ss = 1'b1;
    send_byte(8'hFF);
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 1 || busy !== 1'b1)
      $display("FAIL overrun_no_early_commit pending=%0d busy=%b want=1/1", sb.size(), busy);
    else n_pass++;
    n_checks++;
    if (ovr_cnt - o0 != 1) $display("FAIL overrun_pulse got=%0d want=1", ovr_cnt - o0);
    else n_pass++;
    pulse_fs();
    wait_commit("overrun");
  endtask

  task automatic test_reset_midframe();
    int e0 = err_cnt;
    open_frame();
    send_byte(8'h5A);
    send_byte(8'h6B);
    rst = 1'b1;
    #2;
    n_checks++;
    if (config_out !== RESET_CFG || busy !== 1'b0)
      $display("FAIL midframe_async_reset cfg=%h busy=%b want=%h/0", config_out, busy, RESET_CFG);
    else n_pass++;
    ss = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (err_cnt != e0 || busy !== 1'b0)
      $display("FAIL midframe_no_err err=%0d busy=%b want=0/0", err_cnt - e0, busy);
    else n_pass++;
    send_frame(32'h0BADF00D);
    pulse_fs();
    wait_commit("after_reset");
  endtask

`ifdef CONFIG_CHECKSUM_EN
  task automatic test_checksum();
    int e0 = err_cnt;
    send_frame(32'h01020408);
    pulse_fs();
    wait_commit("checksum_ok");
    open_frame();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08); send_byte(8'h0E);
    ss = 1'b1;
    repeat (3) tick();
    pulse_fs();
    repeat (3) tick();
    n_checks++;
    if (err_cnt - e0 != 1 || config_out !== 32'h01020408)
      $display("FAIL checksum_bad err=%0d cfg=%h want=1/01020408", err_cnt - e0, config_out);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_char_wr();
    test_abort();
    test_timeout();
    test_overrun();
    test_reset_midframe();
`ifdef CONFIG_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
